ram_prog: RTL and testbench
===========================

Name: ram_prog

Overview:
- Parametrised successor to the SAP RAM/MAR block: memory array, memory address register (MAR), run-mode bus read/write, and a program-mode loader.
- Program mode adds what the previous RAM lacked: synchronous writes, a debounced-by-hold pushbutton write strobe, and MAR auto-increment after each programmed byte.
- Sits between the system bus and the front-panel dipswitches; the controller drives the active-low control signals.

Parameters:
- DATA_W, 8, data word width (bus and dipswitch data).
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- AUTO_INC, 1, 1 = MAR increments after each program-mode write; 0 = MAR holds.

Ports:
- clk  in  1  system clock, all state on rising edge
- clear  in  1  synchronous, active-high reset
- prog_mode  in  1  1 = program (dipswitch) mode, 0 = run mode
- dip_addr  in  ADDR_W  dipswitch address
- dip_data  in  DATA_W  dipswitch data
- addr_select  in  1  MAR source: 0 = dip_addr, 1 = bus_in[ADDR_W-1:0]
- load_mar_n  in  1  active-low MAR load
- bus_in  in  DATA_W  bus data/address in
- write_enable_n  in  1  active-low run-mode write strobe, sampled at clk
- prog_btn  in  1  asynchronous program-write pushbutton, active-high
- bus_enable_n  in  1  active-low bus output enable
- bus_out  out  DATA_W  mem[MAR] when driving, else 0
- bus_drive  out  1  high when bus_out is valid
- mar_q  out  ADDR_W  current MAR
- prog_busy  out  1  loader FSM not in IDLE
- prog_done  out  1  one-cycle pulse per programmed byte

Behaviour:
- Reset (clear=1 at edge): MAR=0, FSM=IDLE, synchroniser flops=0, prog_done=0. Memory contents are NOT cleared. clear overrides every other input.
- Read path: combinational from registered MAR. bus_drive = ~bus_enable_n; bus_out = bus_drive ? mem[MAR] : 0. Reads are valid in both modes.
- MAR load: when load_mar_n=0 and prog_busy=0, MAR <= (addr_select ? bus_in[ADDR_W-1:0] : dip_addr) at the edge. While prog_busy=1 the FSM owns MAR and load_mar_n is ignored.
- Run-mode write: when prog_mode=0 and write_enable_n=0 at the edge, mem[MAR] <= bus_in. If the same edge also loads MAR, the write uses the old MAR. write_enable_n is ignored when prog_mode=1.
- Button path: 2-flop synchroniser (s1, s2) plus previous-value flop s3. rise = s2 & ~s3.
- FSM states: IDLE, WRITE, INC, HOLD.
  - IDLE -> WRITE when prog_mode & rise.
  - WRITE -> INC. At this edge mem[MAR] <= dip_data.
  - INC -> HOLD. prog_done=1 for this cycle only. At this edge MAR <= MAR+1 mod 2**ADDR_W if AUTO_INC=1; MAR unchanged if AUTO_INC=0.
  - HOLD -> IDLE when s2=0; otherwise stay in HOLD, so one press yields exactly one byte.
- Latency: prog_btn high before edge E0 gives rise during E1..E2; WRITE during E2..E3; memory written at E3; prog_done high E3..E4; MAR incremented at E4.
- Abort: prog_mode=0 while in WRITE, INC or HOLD -> IDLE at the next edge, with no write and no increment at that edge. clear mid-sequence behaves likewise and also sets MAR=0.
- Wrap: MAR = 2**ADDR_W-1 increments to 0.
- Glitch: a button pulse shorter than one clock period may be missed. Any pulse that is synchronised produces exactly one write.

Decomposition:
- sap_pkg: loader state enum (IDLE/WRITE/INC/HOLD); default DATA_W/ADDR_W constants.
- Sub-module button_sync: 2-flop synchroniser, s3 flop, and rise output; synchronous clear.
- Memory array, MAR and FSM stay in ram_prog.

Test Plan:
- Reset then read: preload mem[0]=0xA5, clear=1 for one edge, bus_enable_n=0 -> mar_q=0, bus_out=0xA5, bus_drive=1. With bus_enable_n=1 -> bus_out=0x00, bus_drive=0.
- MAR sources: addr_select=0, dip_addr=0xA, load_mar_n=0 -> mar_q=0xA. Then addr_select=1, bus_in=0xF7 -> mar_q=0x7.
- Run write: MAR=0x7, prog_mode=0, bus_in=0x3C, write_enable_n=0 for 1 cycle -> bus_out=0x3C. Repeat with prog_mode=1 -> mem[7] unchanged.
- Program sequence: MAR=0xE, dip_data=0xCF, prog_mode=1, prog_btn held high 6 cycles -> mem[0xE]=0xCF, one prog_done pulse, mar_q=0xF, no second write while held. Second press with dip_data=0x11 -> mem[0xF]=0x11, mar_q wraps to 0x0.
- AUTO_INC=0 instance: same press -> byte written, mar_q stays 0xE.
- Abort: press, then drop prog_mode in the WRITE cycle -> memory unchanged, no prog_done, FSM IDLE. Separately assert clear in the INC cycle -> mar_q=0, prog_busy=0.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared types and default sizes for the programmable SAP RAM block.
package sap_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;

   // Program-mode loader: one pass through WRITE/INC per button press,
   // then HOLD until the button is released.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_INC,
      ST_HOLD
   } ld_state_t;

endpackage

// File: rtl/ram_prog_button_sync.sv
// Brings the front-panel program button into the clock domain and flags
// its rising edge. A pulse that misses every clock edge is simply lost.
module ram_prog_button_sync (
   input  logic clk,
   input  logic clear,
   input  logic btn,
   output logic s2,
   output logic rise
);

   logic s1;
   logic s3;

   // Two-flop synchroniser plus a delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (clear) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/ram_prog.sv
// SAP RAM + MAR with run-mode bus access and a dipswitch program loader.
// The loader writes one byte per button press and optionally steps MAR.
module ram_prog
   import sap_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter bit AUTO_INC = 1'b1
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              prog_mode,
   input  logic [ADDR_W-1:0] dip_addr,
   input  logic [DATA_W-1:0] dip_data,
   input  logic              addr_select,
   input  logic              load_mar_n,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              write_enable_n,
   input  logic              prog_btn,
   input  logic              bus_enable_n,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_drive,
   output logic [ADDR_W-1:0] mar_q,
   output logic              prog_busy,
   output logic              prog_done
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   ld_state_t         state_q, state_d;
   logic              s2, rise;
   logic              prog_wr, prog_inc;
   logic [ADDR_W-1:0] mar_src;

   ram_prog_button_sync u_btn (
      .clk   (clk),
      .clear (clear),
      .btn   (prog_btn),
      .s2    (s2),
      .rise  (rise)
   );

   assign mar_src   = addr_select ? bus_in[ADDR_W-1:0] : dip_addr;
   assign bus_drive = ~bus_enable_n;
   assign bus_out   = bus_drive ? mem[mar_q] : '0;

   // Loader state register.
   always_ff @(posedge clk) begin
      if (clear) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Loader next state and strobes; leaving program mode aborts at once.
   always_comb begin
      state_d   = state_q;
      prog_busy = (state_q != ST_IDLE);
      prog_done = (state_q == ST_INC);
      prog_wr   = (state_q == ST_WRITE) && prog_mode;
      prog_inc  = (state_q == ST_INC) && prog_mode && AUTO_INC;
      case (state_q)
         ST_IDLE:  if (prog_mode && rise) state_d = ST_WRITE;
         ST_WRITE: state_d = prog_mode ? ST_INC : ST_IDLE;
         ST_INC:   state_d = prog_mode ? ST_HOLD : ST_IDLE;
         ST_HOLD:  if (!prog_mode || !s2) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // MAR: the loader owns it while busy, otherwise the controller loads it.
   always_ff @(posedge clk) begin
      if (clear)
         mar_q <= '0;
      else if (prog_inc)
         mar_q <= mar_q + ADDR_W'(1);
      else if (!load_mar_n && !prog_busy)
         mar_q <= mar_src;
   end

   // Memory writes use the pre-edge MAR; contents survive clear.
   always_ff @(posedge clk) begin
      if (!clear) begin
         if (prog_wr)
            mem[mar_q] <= dip_data;
         else if (!prog_mode && !write_enable_n)
            mem[mar_q] <= bus_in;
      end
   end

endmodule

// File: tb/tb_ram_prog.sv
// Randomised scoreboard bench for ram_prog: two instances (auto-increment
// on and off) share stimulus; a behavioural model predicts reads and loader
// completions, and negedge monitors pop and compare.
module tb_ram_prog;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          clear = 1'b1, prog_mode = 1'b0, addr_select = 1'b0;
   logic          load_mar_n = 1'b1, write_enable_n = 1'b1;
   logic          prog_btn = 1'b0, bus_enable_n = 1'b1;
   logic [AW-1:0] dip_addr = '0;
   logic [DW-1:0] dip_data = '0, bus_in = '0;

   logic [DW-1:0] bus_out_a, bus_out_b;
   logic          bus_drive_a, bus_drive_b, busy_a, busy_b, done_a, done_b;
   logic [AW-1:0] mar_q_a, mar_q_b;

   ram_prog #(.DATA_W(DW), .ADDR_W(AW), .AUTO_INC(1'b1)) dut_a (
      .clk(clk), .clear(clear), .prog_mode(prog_mode), .dip_addr(dip_addr),
      .dip_data(dip_data), .addr_select(addr_select), .load_mar_n(load_mar_n),
      .bus_in(bus_in), .write_enable_n(write_enable_n), .prog_btn(prog_btn),
      .bus_enable_n(bus_enable_n), .bus_out(bus_out_a), .bus_drive(bus_drive_a),
      .mar_q(mar_q_a), .prog_busy(busy_a), .prog_done(done_a));

   ram_prog #(.DATA_W(DW), .ADDR_W(AW), .AUTO_INC(1'b0)) dut_b (
      .clk(clk), .clear(clear), .prog_mode(prog_mode), .dip_addr(dip_addr),
      .dip_data(dip_data), .addr_select(addr_select), .load_mar_n(load_mar_n),
      .bus_in(bus_in), .write_enable_n(write_enable_n), .prog_btn(prog_btn),
      .bus_enable_n(bus_enable_n), .bus_out(bus_out_b), .bus_drive(bus_drive_b),
      .mar_q(mar_q_b), .prog_busy(busy_b), .prog_done(done_b));

   int n_chk = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   // Reference model: memory image and MAR of each instance.
   logic [DW-1:0] mem_a [DEPTH];
   logic [DW-1:0] mem_b [DEPTH];
   int            mar_a, mar_b;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } rd_exp_t;

   rd_exp_t       rq_a[$], rq_b[$];
   logic [AW-1:0] dq_a[$], dq_b[$];
   rd_exp_t       ea, eb;
   logic [AW-1:0] da, db;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: output with nothing expected", nm);
   endtask

   // Read monitors: each driven cycle consumes one expected read.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus_drive_a) begin
            if (rq_a.size() == 0) unexpected("read_a");
            else begin
               ea = rq_a.pop_front();
               chk("read_a_mar", 32'(mar_q_a), 32'(ea.addr));
               chk("read_a_data", 32'(bus_out_a), 32'(ea.data));
            end
         end else chk("idle_bus_a", 32'(bus_out_a), 32'h0);
         if (bus_drive_b) begin
            if (rq_b.size() == 0) unexpected("read_b");
            else begin
               eb = rq_b.pop_front();
               chk("read_b_mar", 32'(mar_q_b), 32'(eb.addr));
               chk("read_b_data", 32'(bus_out_b), 32'(eb.data));
            end
         end else chk("idle_bus_b", 32'(bus_out_b), 32'h0);
      end
   end

   // Loader-completion monitors: each prog_done cycle consumes one byte.
   always @(negedge clk) begin
      if (mon_en) begin
         if (done_a) begin
            if (dq_a.size() == 0) unexpected("done_a");
            else begin
               da = dq_a.pop_front();
               chk("done_a_mar", 32'(mar_q_a), 32'(da));
            end
         end
         if (done_b) begin
            if (dq_b.size() == 0) unexpected("done_b");
            else begin
               db = dq_b.pop_front();
               chk("done_b_mar", 32'(mar_q_b), 32'(db));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mar_a = 0;
      mar_b = 0;
   endtask

   task automatic do_load(input bit sel, input logic [AW-1:0] dad, input logic [DW-1:0] bi);
      addr_select = sel; dip_addr = dad; bus_in = bi; load_mar_n = 1'b0;
      tick();
      load_mar_n = 1'b1;
      mar_a = sel ? int'(bi) % DEPTH : int'(dad);
      mar_b = mar_a;
   endtask

   task automatic do_wr(input bit pm, input logic [DW-1:0] d);
      prog_mode = pm; bus_in = d; write_enable_n = 1'b0;
      tick();
      write_enable_n = 1'b1; prog_mode = 1'b0;
      if (!pm) begin
         mem_a[mar_a] = d;
         mem_b[mar_b] = d;
      end
   endtask

   // Load and write on the same edge: the byte lands at the old address.
   task automatic do_ldwr(input bit sel, input logic [AW-1:0] dad, input logic [DW-1:0] bi);
      addr_select = sel; dip_addr = dad; bus_in = bi;
      load_mar_n = 1'b0; write_enable_n = 1'b0;
      tick();
      load_mar_n = 1'b1; write_enable_n = 1'b1;
      mem_a[mar_a] = bi;
      mem_b[mar_b] = bi;
      mar_a = sel ? int'(bi) % DEPTH : int'(dad);
      mar_b = mar_a;
   endtask

   task automatic do_read();
      rq_a.push_back(rd_exp_t'{addr: AW'(mar_a), data: mem_a[mar_a]});
      rq_b.push_back(rd_exp_t'{addr: AW'(mar_b), data: mem_b[mar_b]});
      bus_enable_n = 1'b0;
      tick();
      bus_enable_n = 1'b1;
   endtask

   // One press: exactly one byte per instance, and MAR steps only where
   // auto-increment is enabled.
   task automatic do_press(input logic [DW-1:0] d, input int hold);
      prog_mode = 1'b1; dip_data = d; prog_btn = 1'b1;
      dq_a.push_back(AW'(mar_a));
      dq_b.push_back(AW'(mar_b));
      mem_a[mar_a] = d;
      mem_b[mar_b] = d;
      mar_a = (mar_a + 1) % DEPTH;
      repeat (hold) tick();
      prog_btn = 1'b0;
      repeat (6) tick();
      prog_mode = 1'b0;
   endtask

   task automatic check_state(input string nm);
      chk({nm, "_mar_a"}, 32'(mar_q_a), 32'(mar_a));
      chk({nm, "_mar_b"}, 32'(mar_q_b), 32'(mar_b));
      chk({nm, "_busy_a"}, 32'(busy_a), 32'h0);
      chk({nm, "_busy_b"}, 32'(busy_b), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int addr0;
      repeat (2) tick();
      clear = 1'b0;
      mar_a = 0;
      mar_b = 0;
      mon_en = 1'b1;
      chk("rst_mar_a", 32'(mar_q_a), 32'h0);
      chk("rst_busy_a", 32'(busy_a), 32'h0);
      chk("rst_done_a", 32'(done_a), 32'h0);
      chk("rst_mar_b", 32'(mar_q_b), 32'h0);

      // Fill the whole array so every later read has a known value.
      for (int i = 0; i < DEPTH; i++) begin
         do_load(1'b0, AW'(i), '0);
         do_wr(1'b0, DW'($urandom));
      end

      // Memory survives clear; MAR returns to 0.
      do_load(1'b0, 4'h0, '0);
      do_wr(1'b0, 8'hA5);
      do_load(1'b0, 4'h5, '0);
      do_clear();
      check_state("clr");
      do_read();
      tick();

      // MAR from dipswitches, then from the bus low bits.
      do_load(1'b0, 4'hA, '0);
      check_state("ld_dip");
      do_load(1'b1, 4'h0, 8'hF7);
      check_state("ld_bus");

      // Run write, then the same write attempted in program mode.
      do_wr(1'b0, 8'h3C);
      do_read();
      do_wr(1'b1, 8'h99);
      do_read();
      do_ldwr(1'b0, 4'h2, 8'h6B);
      check_state("ldwr");
      do_load(1'b0, 4'h7, '0);
      do_read();

      // Programmed bytes with wrap on the auto-increment instance.
      do_load(1'b0, 4'hE, '0);
      do_press(8'hCF, 6);
      check_state("prog1");
      do_read();
      do_press(8'h11, 6);
      check_state("prog2");
      do_load(1'b0, 4'hF, '0);
      do_read();
      do_load(1'b0, 4'hE, '0);
      do_read();

      // Abort by leaving program mode during WRITE.
      do_load(1'b0, 4'h3, '0);
      prog_mode = 1'b1; dip_data = 8'h5A; prog_btn = 1'b1;
      repeat (3) tick();
      chk("abort_busy_in_write", 32'(busy_a), 32'h1);
      prog_mode = 1'b0;
      tick();
      check_state("abort");
      prog_btn = 1'b0;
      repeat (4) tick();
      do_read();

      // clear during INC: byte already written, MAR forced to 0.
      do_load(1'b0, 4'h9, '0);
      addr0 = mar_a;
      prog_mode = 1'b1; dip_data = 8'hE4; prog_btn = 1'b1;
      dq_a.push_back(AW'(mar_a));
      dq_b.push_back(AW'(mar_b));
      mem_a[mar_a] = 8'hE4;
      mem_b[mar_b] = 8'hE4;
      repeat (4) tick();
      chk("inc_busy", 32'(busy_a), 32'h1);
      prog_btn = 1'b0;
      do_clear();
      check_state("clr_inc");
      prog_mode = 1'b0;
      repeat (4) tick();
      do_load(1'b0, AW'(addr0), '0);
      do_read();

      // Randomised mix of all operations.
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 5))
            0: do_load(1'($urandom), AW'($urandom), DW'($urandom));
            1: do_wr(1'($urandom), DW'($urandom));
            2: do_ldwr(1'($urandom), AW'($urandom), DW'($urandom));
            3: do_press(DW'($urandom), int'($urandom_range(1, 8)));
            default: do_read();
         endcase
         if (n % 10 == 0) check_state("rnd");
      end
      repeat (3) tick();

      chk("left_rd_a", 32'(rq_a.size()), 32'h0);
      chk("left_rd_b", 32'(rq_b.size()), 32'h0);
      chk("left_done_a", 32'(dq_a.size()), 32'h0);
      chk("left_done_b", 32'(dq_b.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
